// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol codes, default timing, tx state encoding.
package morse_pkg;

  // Character layout: five 2-bit symbol slots, slot 0 in bits [1:0]
  localparam int SYMBOL_SLOTS = 5;
  localparam int CHAR_W       = 2 * SYMBOL_SLOTS;

  // Symbol codes; SYM_RSVD is treated exactly like SYM_END
  localparam logic [1:0] SYM_END  = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_RSVD = 2'b11;

  // Default timing in Morse units
  localparam int DEFAULT_DASH_UNITS     = 3;
  localparam int DEFAULT_CHAR_GAP_UNITS = 3;
  localparam int DEFAULT_WORD_GAP_UNITS = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MARK,
    ST_SPACE,
    ST_GAP
  } tx_state_t;

  // True for symbols that produce a mark (DOT or DASH)
  function automatic logic is_mark(input logic [1:0] sym);
    return (sym == SYM_DOT) || (sym == SYM_DASH);
  endfunction

endpackage

// File: rtl/morse_unit_tick.sv
// Unit-time divider: one-cycle tick every UNIT_CYCLES cycles, restartable.
module morse_unit_tick
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(UNIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // The tick marks the last cycle of each unit
  assign tick = (cnt == LAST);

  // Cycle counter; restart forces a fresh unit so segments start aligned
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: keys out one character of DOT/DASH slots on key_out.
module morse_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES    = 12500000,
  parameter int DASH_UNITS     = DEFAULT_DASH_UNITS,
  parameter int CHAR_GAP_UNITS = DEFAULT_CHAR_GAP_UNITS,
  parameter int WORD_GAP_UNITS = DEFAULT_WORD_GAP_UNITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CHAR_W-1:0] char_in,
  input  logic              word_end,
  input  logic              char_valid,
  output logic              char_ready,
  output logic              key_out,
  output logic              busy,
  output logic              done
);

  tx_state_t         state, state_nxt;
  logic [CHAR_W-1:0] shreg;      // remaining symbols, current one in [1:0]
  logic              word_q;     // latched word_end
  logic [2:0]        unit_cnt;   // completed units in the current segment
  logic [2:0]        unit_need;  // length of the current segment in units
  logic              tick;
  logic              seg_end;
  logic              accept;
  logic              restart;

  assign accept  = char_valid && (state == ST_IDLE);
  // Any state change starts a new segment, so both counters restart then
  assign restart = (state_nxt != state);
  assign seg_end = tick && (unit_cnt == unit_need - 3'd1);

  morse_unit_tick #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Segment length for the current state
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    unit_need = 3'd1;
    case (state)
      ST_MARK:  unit_need = (shreg[1:0] == SYM_DASH) ? 3'(DASH_UNITS) : 3'd1;
      ST_SPACE: unit_need = 3'd1;
      ST_GAP:   unit_need = word_q ? 3'(WORD_GAP_UNITS) : 3'(CHAR_GAP_UNITS);
      default:  unit_need = 3'd1;
    endcase
  end

  // Next-state logic; the slot after the current mark decides SPACE vs GAP
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)  state_nxt = is_mark(char_in[1:0]) ? ST_MARK : ST_GAP;
      ST_MARK:  if (seg_end) state_nxt = is_mark(shreg[3:2]) ? ST_SPACE : ST_GAP;
      ST_SPACE: if (seg_end) state_nxt = ST_MARK;
      ST_GAP:   if (seg_end) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Unit counter: counts ticks within a segment, cleared on every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unit_cnt <= '0;
    end else if (restart || state == ST_IDLE) begin
      unit_cnt <= '0;
    end else if (tick) begin
      unit_cnt <= unit_cnt + 3'd1;
    end
  end

  // Symbol shift register and word flag; zero fill makes slot 5+ read as END
  // NOTE: these data registers are reset too, so a discarded character never replays stale symbols.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg  <= '0;
      word_q <= 1'b0;
    end else if (accept) begin
      shreg  <= char_in;
      word_q <= word_end;
    end else if (state == ST_MARK && seg_end) begin
      shreg  <= {2'b00, shreg[CHAR_W-1:2]};
    end
  end

  // Outputs decode registered state only
  assign char_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign key_out    = (state == ST_MARK);
  assign done       = (state == ST_GAP) && seg_end;

endmodule

// File: tb/tb_morse_tx.sv
// Self-checking bench for morse_tx with UNIT_CYCLES = 4.
module tb_morse_tx;

  localparam int U      = 4;
  localparam int DASH_U = 3;
  localparam int CGAP_U = 3;
  localparam int WGAP_U = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] char_in;
  logic       word_end;
  logic       char_valid;
  logic       char_ready;
  logic       key_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];

  typedef struct {
    string      name;
    logic [9:0] ch;
    logic       we;
    bit         keep;   // hold char_valid high and offer the next row during this one
    bit         noise;  // toggle char_valid / char_in while busy
    int         exp_len;
    int         exp_on;
  } vec_t;

  vec_t tbl[$];

  morse_tx #(
    .UNIT_CYCLES(U)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .char_in   (char_in),
    .word_end  (word_end),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .key_out   (key_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected key_out per cycle after acceptance, built from the timing rules
  task automatic build_model(input logic [9:0] ch, input logic we);
    logic [9:0] c;
    logic [1:0] sym;
    c = ch;
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      sym = c[2*k +: 2];
      if (sym != 2'b01 && sym != 2'b10) break;
      if (k > 0) repeat (U) exp_q.push_back(1'b0);
      repeat ((sym == 2'b10 ? DASH_U : 1) * U) exp_q.push_back(1'b1);
    end
    repeat ((we ? WGAP_U : CGAP_U) * U) exp_q.push_back(1'b0);
  endtask

  // Offer a character from IDLE (called at a negedge) and check every cycle
  task automatic run_char(input string name, input logic [9:0] ch, input logic we,
                          input bit keep, input logic [9:0] nch, input logic nwe,
                          input bit noise, output int done_at, output int on_cnt);
    int n;
    build_model(ch, we);
    n = exp_q.size();
    done_at = -1;
    on_cnt  = 0;
    check({name, " ready_before"}, {31'd0, char_ready}, 32'd1);
    char_in    = ch;
    word_end   = we;
    char_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      check({name, " cycle"}, {28'd0, key_out, busy, char_ready, done},
            {28'd0, exp_q[i], 1'b1, 1'b0, (i == n - 1)});
      if (done && done_at < 0) done_at = i + 1;
      if (key_out) on_cnt++;
      if (i == 0 && keep) begin
        char_in  = nch;
        word_end = nwe;
      end else if (!keep) begin
        if (noise && i < n - 1) begin
          char_valid = 1'($urandom_range(0, 1));
          char_in    = 10'($urandom);
          word_end   = 1'($urandom_range(0, 1));
        end else begin
          char_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    check({name, " idle_after"}, {28'd0, key_out, busy, char_ready, done}, 32'b0010);
  endtask

  initial begin
    int d_at, on;
    logic [9:0] rc;
    logic       rw;

    reset      = 1'b1;
    char_in    = '0;
    word_end   = 1'b0;
    char_valid = 1'b0;

    tbl.push_back('{"E",        10'b0000000001, 1'b0, 1'b0, 1'b0, 16, 4});
    tbl.push_back('{"A",        10'b0000001001, 1'b0, 1'b0, 1'b0, 32, 16});
    tbl.push_back('{"T_word",   10'b0000000010, 1'b1, 1'b1, 1'b0, 40, 12});
    tbl.push_back('{"E_held",   10'b0000000001, 1'b0, 1'b0, 1'b0, 16, 4});
    tbl.push_back('{"empty",    10'b0000000000, 1'b1, 1'b0, 1'b0, 28, 0});
    tbl.push_back('{"reserved", 10'b1111111111, 1'b0, 1'b0, 1'b0, 12, 0});
    tbl.push_back('{"dash5",    10'b1010101010, 1'b0, 1'b0, 1'b1, 88, 60});
    tbl.push_back('{"dot5",     10'b0101010101, 1'b0, 1'b0, 1'b0, 48, 20});
    tbl.push_back('{"term_mid", 10'b1010100001, 1'b0, 1'b0, 1'b0, 16, 4});
    tbl.push_back('{"rsvd_mid", 10'b0000110101, 1'b0, 1'b0, 1'b0, 24, 8});

    repeat (2) @(negedge clk);
    check("reset_outputs", {28'd0, key_out, busy, char_ready, done}, 32'b0010);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, char_ready}, 32'd1);

    // Directed table
    for (int i = 0; i < tbl.size(); i++) begin
      run_char(tbl[i].name, tbl[i].ch, tbl[i].we, tbl[i].keep,
               (i + 1 < tbl.size()) ? tbl[i + 1].ch : 10'd0,
               (i + 1 < tbl.size()) ? tbl[i + 1].we : 1'b0,
               tbl[i].noise, d_at, on);
      check({tbl[i].name, " done_at"}, d_at, tbl[i].exp_len);
      check({tbl[i].name, " on_cycles"}, on, tbl[i].exp_on);
    end

    // Random characters against the model
    for (int r = 0; r < 40; r++) begin
      rc = 10'($urandom);
      if (r % 2 == 0) begin
        for (int k = 0; k < 5; k++) rc[2*k +: 2] = 2'($urandom_range(1, 2));
        if ($urandom_range(0, 1) == 1) rc[2*$urandom_range(1, 4) +: 2] = 2'b00;
      end
      rw = 1'($urandom_range(0, 1));
      run_char("random", rc, rw, 1'b0, 10'd0, 1'b0, (r % 3 == 0), d_at, on);
      check("random done_at", d_at, exp_q.size());
    end

    // Reset six cycles into a dash: outputs drop without a clock edge
    char_in    = 10'b0000000010;
    word_end   = 1'b0;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    check("rst_mid mark", {30'd0, key_out, busy}, 32'b11);
    repeat (5) @(negedge clk);
    #1 reset = 1'b1;
    #1 check("rst_mid async", {29'd0, key_out, busy, done}, 32'b000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid ready", {31'd0, char_ready}, 32'd1);
    d_at = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done || key_out || busy) d_at++;
    end
    check("rst_mid quiet", d_at, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
